// File: rtl/psi_round_engine_pkg.sv
// Shared types and constants for the Psi round engine (package psi_pkg).
package psi_pkg;

    localparam int unsigned STATE_W    = 128;
    localparam int unsigned MAX_ROUNDS = 18;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_STREAM = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } fsm_t;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/psi_round_engine_psi.sv
// Combinational Psi round: Gamma (word-wise chi), Pi (word shuffle + rotate),
// Theta (neighbour mix), then round-constant add. State is four 32-bit words.
module psi_round_engine_psi
    import psi_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [STATE_W-1:0] rc_i,
    output logic [STATE_W-1:0] state_o
);

    logic [3:0][31:0] w;
    logic [3:0][31:0] g;
    logic [3:0][31:0] p;
    logic [3:0][31:0] t;

    assign w = state_i;

    for (genvar i = 0; i < 4; i++) begin : g_round
        assign g[i] = w[i] ^ (~rotl32(w[i], 1) & rotl32(w[i], 2));
        // Word i takes word (3i+1) mod 4, rotated by 5i+3
        assign p[i] = rotl32(g[(3 * i + 1) % 4], 5 * i + 3);
        assign t[i] = p[i] ^ rotl32(p[(i + 1) % 4] ^ p[(i + 3) % 4], 1);
    end

    assign state_o = t ^ rc_i;

endmodule

// File: rtl/psi_round_engine.sv
// Iterative Psi sequencer: ROUNDS rounds per job, SINGLE or STREAM output mode.
// Optional abort input enabled by `define PSI_ROUND_ENGINE_ABORT_EN.
module psi_round_engine
    import psi_pkg::*;
#(
    parameter  int unsigned ROUNDS = 12,
    localparam int unsigned RW     = $clog2(ROUNDS + 1)
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PSI_ROUND_ENGINE_ABORT_EN
    input  logic               abort,
`endif
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_mode,
    output logic [RW-1:0]      rc_round,
    input  logic [STATE_W-1:0] rc_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic [RW-1:0]      out_round,
    output logic               out_last
);

    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS);

    fsm_t               fsm_q;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] psi_d;
    logic [STATE_W-1:0] out_data_q;
    logic [RW-1:0]      round_q;
    logic [RW-1:0]      round_d;
    logic [RW-1:0]      rc_round_q;
    logic [RW-1:0]      out_round_q;
    logic               mode_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic               final_round;
    logic               abort_req;

    assign round_d     = round_q + RW'(1);
    assign final_round = (round_d == LAST_ROUND);

`ifdef PSI_ROUND_ENGINE_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    psi_round_engine_psi u_psi (
        .state_i (state_q),
        .rc_i    (rc_data),
        .state_o (psi_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            round_q     <= '0;
            rc_round_q  <= '0;
            mode_q      <= MODE_SINGLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
        end else if (abort_req && fsm_q != IDLE) begin
            // Abort outranks a same-cycle output handshake
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            state_q     <= '0;
        end else begin
            unique case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        state_q    <= in_data;
                        round_q    <= '0;
                        mode_q     <= in_mode;
                        rc_round_q <= RW'(1);
                        fsm_q      <= RUN;
                    end
                end
                RUN: begin
                    state_q <= psi_d;
                    round_q <= round_d;
                    if (mode_q == MODE_STREAM || final_round) begin
                        fsm_q       <= HOLD;
                        out_valid_q <= 1'b1;
                        out_data_q  <= psi_d;
                        out_round_q <= round_d;
                        out_last_q  <= final_round;
                    end else begin
                        rc_round_q <= round_d + RW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            fsm_q <= IDLE;
                        end else begin
                            fsm_q      <= RUN;
                            rc_round_q <= round_d;
                        end
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (fsm_q == IDLE);
    assign rc_round  = rc_round_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/psi_round_engine.md
Name: psi_round_engine

Overview:
- Iterative, parametrised sequencer around the existing combinational Psi round function (Gamma, Pi, Theta, round-constant add).
- Applies Psi ROUNDS times to a 128-bit state, one round per RUN cycle, fetching each round constant from an external ROM.
- Two modes, selected per job: final result only, or every intermediate round output streamed (the per-round key-evolution schedule).
- Valid/ready handshakes on input and output; output backpressure stalls iteration.

Parameters:
- ROUNDS, 12, number of Psi applications per job; legal range 1..18.
- RW, $clog2(ROUNDS+1), width of round index (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  job request.
- in_ready  out  1  engine idle, can accept a job.
- in_data  in  128  initial state.
- in_mode  in  1  0 = SINGLE (final only), 1 = STREAM (every round).
- rc_round  out  RW  round index whose constant is needed this cycle (1..ROUNDS).
- rc_data  in  128  round constant for rc_round, combinational same-cycle return.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  128  state after out_round rounds.
- out_round  out  RW  rounds applied to out_data.
- out_last  out  1  out_round == ROUNDS.

Behaviour:
- Reset and registers:
  - Sync reset: FSM to IDLE; state reg, out_data, out_round, rc_round all 0; out_valid 0; out_last 0.
  - in_ready = (FSM==IDLE), so it is 1 from the first cycle after reset.
  - Reset mid-job discards the job with no output.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - in_valid && in_ready: capture state<=in_data, round<=0, mode_q<=in_mode; go RUN.
  - in_valid seen outside IDLE is ignored and not queued.
- RUN:
  - rc_round = round+1.
  - Each cycle: state<=Psi(state, rc_data); round<=round+1.
  - If mode_q==STREAM or round+1==ROUNDS, go HOLD; else stay RUN.
- HOLD:
  - out_valid=1; out_data=state; out_round=round; out_last=(round==ROUNDS).
  - Outputs stay stable while out_ready=0.
  - On out_ready: if out_last, go IDLE; else go RUN.
- rc_round is only meaningful in RUN; it holds its last value otherwise.
- Latency, SINGLE mode: job accepted at cycle 0; RUN cycles 1..ROUNDS; out_valid first at cycle ROUNDS+1; in_ready again the cycle after the output handshake.
- Throughput, STREAM mode with out_ready tied high: one output every 2 cycles (RUN, HOLD); ROUNDS outputs per job.
- ROUNDS=1: both modes give exactly one output, with out_round=1 and out_last=1.
- Round counter never exceeds ROUNDS and has no wrap-around; RW is sized to hold ROUNDS.
- Psi datapath is purely combinational: one instance, input from the state reg, output to the state reg.

Optional Feature:
- Macro PSI_ROUND_ENGINE_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in RUN or HOLD: next cycle FSM=IDLE, out_valid=0, state reg cleared to 0, no further outputs.
  - abort in IDLE has no effect.
  - abort and out_ready in the same HOLD cycle: abort wins, and that output counts as not taken.
- Undefined: no abort port; jobs always run to completion.

Decomposition:
- Package psi_pkg: STATE_W=128, MAX_ROUNDS=18, mode encodings (MODE_SINGLE=0, MODE_STREAM=1), FSM state typedef {IDLE, RUN, HOLD}.
- One sub-module: an instance of the existing Psi round function. FSM, counter and registers stay in psi_round_engine.
- The round-constant ROM is outside this block.

Test Plan:
- SINGLE, ROUNDS=12, in_data=0, golden RC ROM, out_ready=1 -> single output at cycle 13; out_round=12, out_last=1; out_data = golden 12-fold Psi; in_ready=1 at cycle 14.
- STREAM, ROUNDS=12, in_data=128'h0123...cdef -> 12 outputs with out_round 1..12, each matching golden; only the 12th has out_last=1; rc_round sequence 1..12 in RUN cycles.
- STREAM, out_ready low for 5 cycles on round 3 -> out_data/out_round stable all 5 cycles; rc_round does not advance; round 4 follows one RUN cycle after the handshake.
- in_valid pulsed during RUN with a different in_data -> ignored; current job result unchanged; new job accepted only after out_last handshake.
- rst asserted during RUN at round 5 -> next cycle out_valid=0, in_ready=1, out_data=0; a fresh job then completes correctly.
- PSI_ROUND_ENGINE_ABORT_EN defined: abort in HOLD at round 2 together with out_ready=1 -> IDLE next cycle, no further outputs, in_ready=1; same bench with macro undefined builds with no abort port.
